score_keeper: RTL and testbench

- Upstream of the 4-digit seven-segment display driver in the snake game.
- Tracks the current-game score and the session high score, sequenced by game-state events from the game FSM.
- Produces a registered 16-bit binary value (0..9999) on displayed_number; this feeds the display driver's 16-bit number input directly.
- During game-over, displayed_number alternates between the final score and the high score.

---
 rtl/score_keeper.sv | 181 ++++++++++++++++++
 tb/tb_score_keeper.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// score_keeper: current-game score and session high score for the snake game,
// feeding a registered 0..9999 value to the 4-digit seven-segment driver.
// During game-over the displayed value alternates between final score and
// high score. Optional combo scoring is enabled by defining SCORE_COMBO_EN.
module score_keeper #(
    parameter int POINTS_PER_FOOD = 1,
    parameter int MAX_SCORE       = 9999,
    parameter int SHOW_CYCLES     = 25000000,
    parameter int COMBO_CYCLES    = 50000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        food_eaten,
    input  logic        game_over,
    output logic [15:0] displayed_number,
    output logic [13:0] score,
    output logic [13:0] high_score,
    output logic        playing
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_PLAYING = 2'b01,
        S_OVER    = 2'b10
    } state_t;

    localparam int              ALT_W    = (SHOW_CYCLES > 2) ? $clog2(SHOW_CYCLES) : 1;
    localparam logic [ALT_W-1:0] ALT_LAST = ALT_W'(SHOW_CYCLES - 1);
    localparam logic [14:0]     MAX_W    = 15'(MAX_SCORE);
    localparam logic [14:0]     PTS_1    = 15'(POINTS_PER_FOOD);

    state_t             r_state;
    state_t             w_state_next;
    logic [13:0]        r_score;
    logic [13:0]        r_high;
    logic [15:0]        r_disp;
    logic               r_food_d;
    logic [ALT_W-1:0]   r_alt_timer;
    logic               r_alt_sel;
    logic               w_eat;
    logic               w_start_game;
    logic [14:0]        w_pts;
    logic [13:0]        w_score_inc;
    logic [13:0]        w_final;
    logic [13:0]        w_src;

    // Saturating add: sum is formed 15 bits wide so it can never wrap.
    function automatic logic [13:0] sat_add(input logic [13:0] base, input logic [14:0] pts);
        logic [14:0] sum;
        sum = {1'b0, base} + pts;
        return (sum > MAX_W) ? MAX_W[13:0] : sum[13:0];
    endfunction

    function automatic logic [13:0] max14(input logic [13:0] a, input logic [13:0] b);
        return (a > b) ? a : b;
    endfunction

    assign w_eat        = food_eaten & ~r_food_d;
    assign w_start_game = start && ((r_state == S_IDLE) || (r_state == S_OVER));
    assign w_score_inc  = sat_add(r_score, w_pts);
    // An eat coinciding with game_over still counts toward the final score.
    assign w_final      = w_eat ? w_score_inc : r_score;

`ifdef SCORE_COMBO_EN
    localparam int               CMB_W    = $clog2(COMBO_CYCLES + 1);
    localparam logic [CMB_W-1:0] CMB_LOAD = CMB_W'(COMBO_CYCLES);

    logic [CMB_W-1:0] r_combo_timer;

    // Combo window: reload on every eat while playing, otherwise count down to 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_combo_timer <= '0;
        end else if (w_start_game) begin
            r_combo_timer <= '0;
        end else if ((r_state == S_PLAYING) && w_eat) begin
            r_combo_timer <= CMB_LOAD;
        end else if (r_combo_timer != '0) begin
            r_combo_timer <= r_combo_timer - 1'b1;
        end
    end

    assign w_pts = (r_combo_timer != '0) ? 15'(2 * POINTS_PER_FOOD) : PTS_1;
`else
    assign w_pts = PTS_1;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and display-source selection; start wins over game_over outside PLAYING.
    always_comb begin
        w_state_next = r_state;
        w_src        = r_high;
        case (r_state)
            S_IDLE: begin
                w_src = r_high;
                if (start) w_state_next = S_PLAYING;
            end
            S_PLAYING: begin
                w_src = r_score;
                if (game_over) w_state_next = S_OVER;
            end
            S_OVER: begin
                w_src = r_alt_sel ? r_high : r_score;
                if (start) w_state_next = S_PLAYING;
            end
            default: begin
                w_src        = r_high;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Edge detector history, sampled in every state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_food_d <= 1'b0;
        end else begin
            r_food_d <= food_eaten;
        end
    end

    // Current score: cleared on game start, saturating increment per eat while playing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_score <= '0;
        end else if (w_start_game) begin
            r_score <= '0;
        end else if ((r_state == S_PLAYING) && w_eat) begin
            r_score <= w_score_inc;
        end
    end

    // High score: updated on the game-over edge with the final score.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_high <= '0;
        end else if ((r_state == S_PLAYING) && game_over) begin
            r_high <= max14(r_high, w_final);
        end
    end

    // Game-over alternation timer; held at zero outside OVER so OVER starts clean.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alt_timer <= '0;
            r_alt_sel   <= 1'b0;
        end else if ((r_state != S_OVER) || start) begin
            r_alt_timer <= '0;
            r_alt_sel   <= 1'b0;
        end else if (r_alt_timer == ALT_LAST) begin
            r_alt_timer <= '0;
            r_alt_sel   <= ~r_alt_sel;
        end else begin
            r_alt_timer <= r_alt_timer + 1'b1;
        end
    end

    // Registered display value; lags score/high_score by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_disp <= '0;
        end else begin
            r_disp <= {2'b00, w_src};
        end
    end

    assign displayed_number = r_disp;
    assign score            = r_score;
    assign high_score       = r_high;
    assign playing          = (r_state == S_PLAYING);

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: stimulus queues expected values tagged
// with the cycle they apply to; a monitor compares them on the falling edge.
module tb_score_keeper;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        food_eaten = 1'b0;
    logic        game_over = 1'b0;
    logic [15:0] displayed_number;
    logic [13:0] score;
    logic [13:0] high_score;
    logic        playing;

    score_keeper #(
        .POINTS_PER_FOOD(1),
        .MAX_SCORE(9999),
        .SHOW_CYCLES(8),
        .COMBO_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .food_eaten(food_eaten),
        .game_over(game_over),
        .displayed_number(displayed_number),
        .score(score),
        .high_score(high_score),
        .playing(playing)
    );

    always #5 clk = ~clk;

    localparam int SIG_SCORE = 0;
    localparam int SIG_HIGH  = 1;
    localparam int SIG_DISP  = 2;
    localparam int SIG_PLAY  = 3;
    localparam int SIG_STATE = 4;

    typedef struct {
        string name;
        int    sig;
        int    exp;
        int    at;
    } chk_t;

    chk_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    initial forever begin
        @(posedge clk);
        cyc <= cyc + 1;
    end

    // Monitor: pops every expectation due at this cycle and compares it.
    initial forever begin
        chk_t c;
        int   act;
        @(negedge clk);
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            c = sb.pop_front();
            case (c.sig)
                SIG_SCORE: act = int'(score);
                SIG_HIGH:  act = int'(high_score);
                SIG_DISP:  act = int'(displayed_number);
                SIG_PLAY:  act = int'(playing);
                default:   act = int'(dut.r_state);
            endcase
            n_checks++;
            if (c.at != cyc) begin
                n_fail++;
                $display("FAIL %s: check due at cycle %0d missed (now %0d)", c.name, c.at, cyc);
            end else if (act != c.exp) begin
                n_fail++;
                $display("FAIL %s: got %0d expected %0d (cycle %0d)", c.name, act, c.exp, cyc);
            end
        end
    end

    task automatic expect_at(input string name, input int sig, input int value, input int delay);
        chk_t c;
        c.name = name;
        c.sig  = sig;
        c.exp  = value;
        c.at   = cyc + delay;
        sb.push_back(c);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic eat_pulse();
        food_eaten = 1'b1;
        step(1);
        food_eaten = 1'b0;
        step(1);
    endtask

    task automatic eats(input int n);
        for (int i = 0; i < n; i++) eat_pulse();
    endtask

    task automatic begin_game();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic end_game();
        game_over = 1'b1;
        step(1);
        game_over = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on reset.
        step(2);
        reset = 1'b0;
        expect_at("rst_score", SIG_SCORE, 0, 0);
        expect_at("rst_high",  SIG_HIGH,  0, 0);
        expect_at("rst_disp",  SIG_DISP,  0, 0);
        expect_at("rst_play",  SIG_PLAY,  0, 0);
        step(1);

`ifndef SCORE_COMBO_EN
        // Held food scores once, then two single pulses.
        begin_game();
        expect_at("play_on", SIG_PLAY, 1, 0);
        food_eaten = 1'b1;
        step(10);
        expect_at("hold_once", SIG_SCORE, 1, 0);
        food_eaten = 1'b0;
        step(1);
        food_eaten = 1'b1;
        step(1);
        food_eaten = 1'b0;
        step(1);
        food_eaten = 1'b1;
        step(1);
        food_eaten = 1'b0;
        expect_at("pulse_score", SIG_SCORE, 3, 0);
        expect_at("pulse_disp",  SIG_DISP,  3, 1);
        step(1);

        // Game 1 ends at 7; game 2 at 5 is aborted by asynchronous reset.
        eats(4);
        end_game();
        expect_at("g1_high", SIG_HIGH, 7, 0);
        expect_at("g1_play", SIG_PLAY, 0, 0);
        step(1);
        begin_game();
        eats(5);
        expect_at("g2_score", SIG_SCORE, 5, 0);
        step(1);
        #1;
        reset = 1'b1;
        expect_at("arst_score", SIG_SCORE, 0, 0);
        expect_at("arst_high",  SIG_HIGH,  0, 0);
        expect_at("arst_disp",  SIG_DISP,  0, 0);
        expect_at("arst_play",  SIG_PLAY,  0, 0);
        expect_at("arst_state", SIG_STATE, 0, 0);
        step(1);
        reset = 1'b0;
        step(1);

        // Game 3 sets high 4; game 4 eats on the game_over edge at score 4.
        begin_game();
        eats(4);
        end_game();
        expect_at("g3_high", SIG_HIGH, 4, 0);
        step(1);
        begin_game();
        expect_at("restart_score", SIG_SCORE, 0, 0);
        eats(4);
        food_eaten = 1'b1;
        game_over  = 1'b1;
        step(1);
        food_eaten = 1'b0;
        game_over  = 1'b0;
        expect_at("coinc_score", SIG_SCORE, 5, 0);
        expect_at("coinc_high",  SIG_HIGH,  5, 0);
        expect_at("coinc_state", SIG_STATE, 2, 0);
        step(1);

        // Game 5 sets high 9; game 6 ends at 3, then alternation 3/9/3.
        begin_game();
        eats(9);
        end_game();
        step(1);
        begin_game();
        eats(3);
        end_game();
        expect_at("g6_high", SIG_HIGH, 9, 0);
        for (int d = 1; d <= 24; d++) begin
            expect_at("alt_disp", SIG_DISP, (d <= 8) ? 3 : ((d <= 16) ? 9 : 3), d);
        end
        step(24);
        start = 1'b1;
        step(1);
        start = 1'b0;
        expect_at("over_restart_play", SIG_PLAY, 1, 0);
        expect_at("over_restart_disp", SIG_DISP, 0, 1);
        step(1);

        // Saturation at 9999.
        eats(9998);
        expect_at("sat_pre", SIG_SCORE, 9998, 0);
        eats(3);
        expect_at("sat_score", SIG_SCORE, 9999, 0);
        expect_at("sat_disp",  SIG_DISP,  9999, 0);
        end_game();
        expect_at("sat_high", SIG_HIGH, 9999, 0);
        step(1);
`else
        // Combo window of 16 cycles: eats at t=0, t=10, t=40.
        begin_game();
        eat_pulse();
        expect_at("combo_first", SIG_SCORE, 1, 0);
        step(8);
        eat_pulse();
        expect_at("combo_double", SIG_SCORE, 3, 0);
        step(28);
        eat_pulse();
        expect_at("combo_expired", SIG_SCORE, 4, 0);
        step(1);
`endif

        step(3);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d checks left unevaluated, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
